// File: rtl/local_pht_pkg.sv
// Shared fetch-stage branch predictor definitions.
// Holds the index/counter widths, the counter reset value and the update
// record used by the local PHT, the global PHT and the chooser.
package local_pht_pkg;

  localparam int BP_IDX_W = 10;
  localparam int BP_CTR_W = 3;
  // Weakly not-taken: MSB clear, one step below the taken threshold.
  localparam logic [BP_CTR_W-1:0] BP_CTR_INIT = 3'b011;

  // One committed conditional branch as carried down the update pipe.
  typedef struct packed {
    logic                vld;
    logic [BP_IDX_W-1:0] idx;
    logic                taken;
  } bp_upd_t;

endpackage

// File: rtl/local_pht_if.sv
// Fetch-side bundle of the local PHT: lookup request, fetch control,
// registered prediction and retire-side training update.
// master = fetch/retire driver, slave = the PHT itself.
interface local_pht_if
  import local_pht_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int CTR_W = BP_CTR_W
) ();

  logic             pht_rd_en_i;
  logic [IDX_W-1:0] pht_rd_index_i;
  logic             pht_stall_i;
  logic             pht_flush_i;
  logic             pht_pred_vld_o;
  logic             pht_pred_taken_o;
  logic [CTR_W-1:0] pht_pred_ctr_o;
  logic             pht_upd_vld_i;
  logic [IDX_W-1:0] pht_upd_index_i;
  logic             pht_upd_taken_i;

  modport master (
    output pht_rd_en_i, pht_rd_index_i, pht_stall_i, pht_flush_i,
    output pht_upd_vld_i, pht_upd_index_i, pht_upd_taken_i,
    input  pht_pred_vld_o, pht_pred_taken_o, pht_pred_ctr_o
  );

  modport slave (
    input  pht_rd_en_i, pht_rd_index_i, pht_stall_i, pht_flush_i,
    input  pht_upd_vld_i, pht_upd_index_i, pht_upd_taken_i,
    output pht_pred_vld_o, pht_pred_taken_o, pht_pred_ctr_o
  );

endinterface

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down counter step, shared by all predictors.
// Ports: ctr_i current value, taken_i direction (1 = up, 0 = down),
// ctr_o next value clamped to [0, 2**CTR_W-1]. Purely combinational.
module bp_sat_ctr
  import local_pht_pkg::*;
#(
  parameter int CTR_W = BP_CTR_W
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != {CTR_W{1'b1}})) begin
      ctr_o = ctr_i + 1'b1;
    end else if (!taken_i && (ctr_i != {CTR_W{1'b0}})) begin
      ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/local_pht.sv
// Local pattern history table: 2**IDX_W flop-based saturating counters.
// Ports: clock, reset_n (async, active-low), pht (slave side of local_pht_if).
// Lookup latency 1 cycle; update visible 2 cycles later (bypassed one earlier);
// no backpressure, one update accepted every cycle.
module local_pht
  import local_pht_pkg::*;
#(
  parameter int               IDX_W    = BP_IDX_W,
  parameter int               CTR_W    = BP_CTR_W,
  parameter logic [CTR_W-1:0] CTR_INIT = BP_CTR_INIT
) (
  input  logic       clock,
  input  logic       reset_n,
  local_pht_if.slave pht
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [CTR_W-1:0] table_q [DEPTH];

  // U1 stage: the retire update is registered unconditionally.
  logic             upd_vld_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;

  logic [CTR_W-1:0] upd_new_ctr;
  logic [CTR_W-1:0] rd_ctr;

  logic             pred_vld_q;
  logic [CTR_W-1:0] pred_ctr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upd_vld_q   <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_vld_q   <= pht.pht_upd_vld_i;
      upd_idx_q   <= pht.pht_upd_index_i;
      upd_taken_q <= pht.pht_upd_taken_i;
    end
  end

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_i   (table_q[upd_idx_q]),
    .taken_i (upd_taken_q),
    .ctr_o   (upd_new_ctr)
  );

  // The write lands on the edge after U1, so a following U1 to the same
  // entry always reads the already-updated value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (upd_vld_q) begin
      table_q[upd_idx_q] <= upd_new_ctr;
    end
  end

  // A lookup hitting the entry being written this edge sees the new value.
  always_comb begin
    rd_ctr = table_q[pht.pht_rd_index_i];
    if (upd_vld_q && (upd_idx_q == pht.pht_rd_index_i)) begin
      rd_ctr = upd_new_ctr;
    end
  end

  // Flush beats stall beats a normal capture/idle cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_vld_q <= 1'b0;
      pred_ctr_q <= CTR_INIT;
    end else if (pht.pht_flush_i) begin
      pred_vld_q <= 1'b0;
    end else if (!pht.pht_stall_i) begin
      pred_vld_q <= pht.pht_rd_en_i;
      if (pht.pht_rd_en_i) begin
        pred_ctr_q <= rd_ctr;
      end
    end
  end

  assign pht.pht_pred_vld_o   = pred_vld_q;
  assign pht.pht_pred_ctr_o   = pred_ctr_q;
  assign pht.pht_pred_taken_o = pred_ctr_q[CTR_W-1];

endmodule

// File: tb/tb_local_pht.sv
// Directed test of local_pht: table-driven lookup/update vectors followed by
// hand-written stall/flush and mid-stream reset sequences.
module tb_local_pht;
  import local_pht_pkg::*;

  logic clock;
  logic reset_n;

  local_pht_if pif ();

  local_pht dut (
    .clock   (clock),
    .reset_n (reset_n),
    .pht     (pif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rd_en;
    logic [9:0] rd_idx;
    logic       upd_vld;
    logic [9:0] upd_idx;
    logic       upd_taken;
    logic       chk;
    logic       exp_vld;
    logic [2:0] exp_ctr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pred(input string tag, input logic vld, input logic [2:0] ctr);
    check({tag, "_vld"},   {31'd0, pif.pht_pred_vld_o},   {31'd0, vld});
    check({tag, "_ctr"},   {29'd0, pif.pht_pred_ctr_o},   {29'd0, ctr});
    check({tag, "_taken"}, {31'd0, pif.pht_pred_taken_o}, {31'd0, ctr[2]});
  endtask

  function automatic vec_t mk(input logic rd_en, input logic [9:0] rd_idx,
                              input logic upd_vld, input logic [9:0] upd_idx,
                              input logic upd_taken, input logic exp_vld,
                              input logic [2:0] exp_ctr);
    vec_t v;
    v.rd_en     = rd_en;
    v.rd_idx    = rd_idx;
    v.upd_vld   = upd_vld;
    v.upd_idx   = upd_idx;
    v.upd_taken = upd_taken;
    v.chk       = 1'b1;
    v.exp_vld   = exp_vld;
    v.exp_ctr   = exp_ctr;
    return v;
  endfunction

  task automatic idle_inputs();
    pif.pht_rd_en_i     = 1'b0;
    pif.pht_rd_index_i  = '0;
    pif.pht_stall_i     = 1'b0;
    pif.pht_flush_i     = 1'b0;
    pif.pht_upd_vld_i   = 1'b0;
    pif.pht_upd_index_i = '0;
    pif.pht_upd_taken_i = 1'b0;
  endtask

  initial begin
    // lookups of the corner indices from reset
    vecs[0]  = mk(1, 10'd0,    0, 10'h000, 0, 1, 3'd3);
    vecs[1]  = mk(1, 10'd511,  0, 10'h000, 0, 1, 3'd3);
    vecs[2]  = mk(1, 10'd1023, 0, 10'h000, 0, 1, 3'd3);
    vecs[3]  = mk(0, 10'd0,    0, 10'h000, 0, 0, 3'd3);
    // four takens to 0x155: 3->4->5->6->7, last one seen through the bypass
    vecs[4]  = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd3);
    vecs[5]  = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd3);
    vecs[6]  = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd3);
    vecs[7]  = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd3);
    vecs[8]  = mk(1, 10'h155,  0, 10'h000, 0, 1, 3'd7);
    // five more takens: saturates at 7
    vecs[9]  = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd7);
    vecs[10] = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd7);
    vecs[11] = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd7);
    vecs[12] = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd7);
    vecs[13] = mk(0, 10'd0,    1, 10'h155, 1, 0, 3'd7);
    vecs[14] = mk(1, 10'h155,  0, 10'h000, 0, 1, 3'd7);
    // six not-takens to 0x2AA: 3->2->1->0->0->0->0
    vecs[15] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[16] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[17] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[18] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[19] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[20] = mk(0, 10'd0,    1, 10'h2AA, 0, 0, 3'd7);
    vecs[21] = mk(1, 10'h2AA,  0, 10'h000, 0, 1, 3'd0);
    // taken to 0x0F0 then immediate lookup: bypass gives 4
    vecs[22] = mk(0, 10'd0,    1, 10'h0F0, 1, 0, 3'd0);
    vecs[23] = mk(1, 10'h0F0,  0, 10'h000, 0, 1, 3'd4);
    // taken to 0x0F0 then lookup of neighbour 0x0F1: unaffected
    vecs[24] = mk(0, 10'd0,    1, 10'h0F0, 1, 0, 3'd4);
    vecs[25] = mk(1, 10'h0F1,  0, 10'h000, 0, 1, 3'd3);
    // plain table read of 0x0F0 after both writes landed
    vecs[26] = mk(1, 10'h0F0,  0, 10'h000, 0, 1, 3'd5);

    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check_pred("reset", 1'b0, 3'd3);
    #2 reset_n = 1'b1;
    tick();
    check_pred("post_reset", 1'b0, 3'd3);

    for (int i = 0; i < NV; i++) begin
      pif.pht_rd_en_i     = vecs[i].rd_en;
      pif.pht_rd_index_i  = vecs[i].rd_idx;
      pif.pht_upd_vld_i   = vecs[i].upd_vld;
      pif.pht_upd_index_i = vecs[i].upd_idx;
      pif.pht_upd_taken_i = vecs[i].upd_taken;
      tick();
      if (vecs[i].chk) begin
        check_pred($sformatf("row%0d", i), vecs[i].exp_vld, vecs[i].exp_ctr);
      end
    end
    idle_inputs();

    // stall holds the captured prediction while rd_index moves
    pif.pht_rd_en_i    = 1'b1;
    pif.pht_rd_index_i = 10'h0F0;
    tick();
    check_pred("stall_cap", 1'b1, 3'd5);
    pif.pht_stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pif.pht_rd_index_i = (k == 1) ? 10'h2AA : 10'h155;
      tick();
      check_pred($sformatf("stall_hold%0d", k), 1'b1, 3'd5);
    end
    // flush during stall clears valid
    pif.pht_flush_i = 1'b1;
    tick();
    check("flush_stall_vld", {31'd0, pif.pht_pred_vld_o}, 32'd0);
    // flush beats rd_en without stall
    pif.pht_stall_i    = 1'b0;
    pif.pht_rd_index_i = 10'h155;
    pif.pht_rd_en_i    = 1'b1;
    tick();
    check("flush_rden_vld", {31'd0, pif.pht_pred_vld_o}, 32'd0);
    idle_inputs();
    tick();
    check("idle_vld", {31'd0, pif.pht_pred_vld_o}, 32'd0);

    // reset mid-stream with a taken update to 0x3FF sitting in U1
    pif.pht_rd_en_i     = 1'b1;
    pif.pht_rd_index_i  = 10'h155;
    pif.pht_upd_vld_i   = 1'b1;
    pif.pht_upd_index_i = 10'h3FF;
    pif.pht_upd_taken_i = 1'b1;
    tick();
    check_pred("pre_rst", 1'b1, 3'd7);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    check_pred("async_rst", 1'b0, 3'd3);
    tick();
    #2 reset_n = 1'b1;
    tick();
    check("rst_idle_vld", {31'd0, pif.pht_pred_vld_o}, 32'd0);
    tick();
    check("rst_idle_vld2", {31'd0, pif.pht_pred_vld_o}, 32'd0);
    pif.pht_rd_en_i    = 1'b1;
    pif.pht_rd_index_i = 10'h3FF;
    tick();
    check_pred("rst_3ff", 1'b1, 3'd3);
    pif.pht_rd_index_i = 10'h155;
    tick();
    check_pred("rst_155", 1'b1, 3'd3);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/local_pht.md
# local_pht

Local pattern history table for the fetch stage. It sits directly downstream of the branch history table: it is indexed by the 10-bit local branch history that table produces and returns a registered taken/not-taken prediction to the fetch PC-select logic. Committed branch outcomes from retire train its 1024 three-bit saturating counters through a one-stage update pipeline.

## Interface
Parameters:
- IDX_W, 10, index width; the table holds 2**IDX_W entries
- CTR_W, 3, counter width
- CTR_INIT, 3'b011, reset value of every counter (weakly not-taken)

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- pht_rd_en_i  in  1  lookup request this cycle
- pht_rd_index_i  in  IDX_W  lookup index (local history from the BHT)
- pht_stall_i  in  1  fetch stall; hold the prediction registers
- pht_flush_i  in  1  fetch redirect; invalidate the pending prediction
- pht_pred_vld_o  out  1  prediction valid
- pht_pred_taken_o  out  1  predicted direction (counter MSB)
- pht_pred_ctr_o  out  CTR_W  raw counter value, for the chooser and for debug
- pht_upd_vld_i  in  1  committed conditional branch
- pht_upd_index_i  in  IDX_W  history this branch was predicted with (carried down the pipe)
- pht_upd_taken_i  in  1  resolved direction

## Operation
- Table: 2**IDX_W × CTR_W flops. All entries go to CTR_INIT on reset. There is no SRAM and no synchronous clear.
- Lookup: on an edge with pht_rd_en_i=1, pht_stall_i=0 and pht_flush_i=0, capture the counter at pht_rd_index_i into pred_ctr and set pred_vld=1.
- On an edge with pht_rd_en_i=0, pht_stall_i=0 and pht_flush_i=0, set pred_vld=0. pred_ctr holds its value.
- pht_flush_i=1 clears pred_vld on that edge. Flush takes priority over stall and over rd_en.
- pht_stall_i=1 without flush holds pred_vld and pred_ctr unchanged.
- pht_pred_taken_o = pred_ctr[CTR_W-1].
- Update stage U1: every edge registers upd_vld_q, upd_idx_q and upd_taken_q from the inputs. Stall and flush do not affect this.
- Update write: while upd_vld_q=1, compute the new value from table[upd_idx_q] and write it on the next edge.
  - Taken: increment, saturating at 2**CTR_W-1.
  - Not taken: decrement, saturating at 0.
- Read/write collision: if a lookup capture and a U1 write hit the same index on the same edge, the prediction takes the post-update value (bypass). Other indices are unaffected.
- Back-to-back updates to the same index: no hazard, because the U1 write lands before the next U1 read. Two consecutive takens from 3 give 5.
- Every cycle accepts one update; there is no backpressure.

## Timing
- Lookup latency: 1 cycle. An index presented in cycle N gives a prediction valid in cycle N+1.
- Update latency: an update presented in cycle N is visible in the table from cycle N+2. A lookup captured at the N+1→N+2 edge to the same index sees it through the bypass.
- Reset values:
  - pht_pred_vld_o = 0
  - pht_pred_ctr_o = CTR_INIT
  - pht_pred_taken_o = CTR_INIT MSB (0)
  - U1 valid = 0
- Reset asserted mid-update: the pending update is discarded and the whole table returns to CTR_INIT.

## Structure
- Shared fetch package holds:
  - BP_IDX_W = 10
  - BP_CTR_W = 3
  - BP_CTR_INIT
  - a typedef for the update record {vld, idx, taken}, reused by the global PHT and the chooser
- One sub-module, bp_sat_ctr: combinational saturating up/down counter (ctr_i, taken_i → ctr_o). It is shared with the global predictor and the chooser.
- Row-grouped write enables are permitted for power, provided they are functionally identical to a single decoded enable.

## Test plan
- Reset, then look up indices 0, 511 and 1023 → pred_vld=1, ctr=3, taken=0 one cycle after each request.
- Four taken updates to index 0x155, then a lookup → ctr=7 and taken=1. Five further taken updates, then a lookup → ctr still 7.
- Four not-taken updates to 0x2AA from reset → counter reaches 0 and stays 0 after additional not-taken updates.
- Update taken to 0x0F0 in cycle N with a lookup of 0x0F0 in cycle N+1 → prediction shows ctr=4 (bypass). The same sequence with lookup index 0x0F1 → ctr=3.
- Lookup issued, then stall held for 3 cycles with rd_index changing → outputs hold the first value. A flush asserted during the stall → pred_vld=0 on the next edge.
- Assert reset_n low mid-stream after a taken update to 0x3FF has been presented → after release, a lookup of 0x3FF returns ctr=3 and pred_vld stays 0 until the next rd_en.
